// File: rtl/udp_packet_rx.sv
// udp_packet_rx: Ethernet/IPv4/UDP receive filter that streams the UDP payload and checks the FCS.
module udp_packet_rx #(
  parameter string       MODE     = "BYTES",
  parameter logic [47:0] MAC_ADDR = 48'hD8D38526C578,
  parameter logic [15:0] UDP_PORT = 16'hC360
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic       rx_dv,
  input  logic [7:0] id,
  output logic [7:0] od,
  output logic       od_valid,
  output logic       od_sof,
  output logic       od_eof,
  output logic       pkt_done,
  output logic       pkt_ok,
  output logic       drop
);
  localparam bit NIB = (MODE == "NIBBLES");
  localparam logic [31:0] RESIDUE = 32'hDEBB20E3;

  typedef enum logic [2:0] {WAIT_IDLE, IDLE, PREAMBLE, HEADER, PAYLOAD, FCS_WAIT, DROP} state_t;
  state_t state_q, state_d;

  logic        rx_dv_q, ph_q, ph_d;
  logic [3:0]  hi_q, hi_d;
  logic [10:0] idx_q, idx_d;
  logic [2:0]  pre_q, pre_d;
  logic [15:0] len_q, len_d, pay_q, pay_d;
  logic [31:0] crc_q, crc_d;
  logic        mac_q, mac_d, bc_q, bc_d;
  logic [7:0]  od_q, od_d;
  logic        ov_q, ov_d, sof_q, sof_d, eof_q, eof_d;
  logic        done_q, done_d, ok_q, ok_d, drop_q, drop_d;

  logic        ph, byte_v, m_n, bc_n, hdr_ok;
  logic [7:0]  b;
  logic [47:0] mac_sh;
  logic [15:0] len_n, plen;

  function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int i = 0; i < 8; i++) r = r[0] ? (r >> 1) ^ 32'hEDB88320 : r >> 1;
    return r;
  endfunction

  // In nibble mode a rising rx_dv always restarts on the high nibble.
  assign ph     = (NIB && rx_dv && !rx_dv_q) ? 1'b0 : ph_q;
  assign byte_v = rx_dv && (!NIB || ph);
  assign b      = NIB ? {hi_q, id[3:0]} : id;
  assign ph_d   = NIB ? (rx_dv ? ~ph : ph_q) : 1'b0;
  assign hi_d   = (rx_dv && !ph) ? id[3:0] : hi_q;

  assign mac_sh = MAC_ADDR << {idx_q[2:0], 3'b000};
  assign m_n    = mac_q && (b == mac_sh[47:40]);
  assign bc_n   = bc_q && (b == 8'hFF);
  assign len_n  = {len_q[15:8], b};
  assign plen   = len_q - 16'd8;
  assign hdr_ok = idx_q < 11'd6    ? (m_n || bc_n) :
                  idx_q == 11'd12  ? b == 8'h08 :
                  idx_q == 11'd13  ? b == 8'h00 :
                  idx_q == 11'd14  ? b == 8'h45 :
                  idx_q == 11'd23  ? b == 8'h11 :
                  idx_q == 11'd36  ? b == UDP_PORT[15:8] :
                  idx_q == 11'd37  ? b == UDP_PORT[7:0] :
                  idx_q == 11'd39  ? len_n >= 16'd8 : 1'b1;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    pre_d   = pre_q;
    len_d   = len_q;
    pay_d   = pay_q;
    crc_d   = crc_q;
    mac_d   = mac_q;
    bc_d    = bc_q;
    od_d    = od_q;
    ov_d    = 1'b0;
    sof_d   = 1'b0;
    eof_d   = 1'b0;
    done_d  = 1'b0;
    ok_d    = 1'b0;
    case (state_q)
      WAIT_IDLE: state_d = rx_dv ? WAIT_IDLE : IDLE;
      IDLE: if (byte_v) begin
        state_d = (b == 8'h55) ? PREAMBLE : DROP;
        pre_d   = 3'd1;
      end
      PREAMBLE:
        if (!rx_dv) state_d = IDLE;
        else if (byte_v) begin
          if (b == 8'hD5) begin
            state_d = HEADER;
            idx_d   = '0;
            crc_d   = '1;
            mac_d   = 1'b1;
            bc_d    = 1'b1;
            len_d   = '0;
            pay_d   = '0;
          end else if (b == 8'h55 && pre_q != 3'd7) pre_d = pre_q + 3'd1;
          else state_d = DROP;
        end
      HEADER, PAYLOAD, FCS_WAIT:
        if (!rx_dv) begin
          state_d = IDLE;
          done_d  = 1'b1;
          ok_d    = crc_q == RESIDUE && pay_q == plen && !(NIB && ph_q);
        end else if (byte_v) begin
          crc_d = crc_upd(crc_q, b);
          idx_d = (idx_q == 11'h7FF) ? idx_q : idx_q + 11'd1;
          if (state_q == HEADER) begin
            mac_d   = (idx_q < 11'd6) ? m_n : mac_q;
            bc_d    = (idx_q < 11'd6) ? bc_n : bc_q;
            len_d   = (idx_q == 11'd38) ? {b, len_q[7:0]} : (idx_q == 11'd39) ? len_n : len_q;
            state_d = !hdr_ok ? DROP : (idx_q == 11'd41) ? ((len_q > 16'd8) ? PAYLOAD : FCS_WAIT) : HEADER;
          end else if (state_q == PAYLOAD) begin
            od_d    = b;
            ov_d    = 1'b1;
            sof_d   = pay_q == 16'd0;
            eof_d   = pay_q == plen - 16'd1;
            pay_d   = pay_q + 16'd1;
            state_d = eof_d ? FCS_WAIT : PAYLOAD;
          end
        end
      DROP: state_d = rx_dv ? DROP : IDLE;
      default: state_d = WAIT_IDLE;
    endcase
    drop_d = state_d == DROP && state_q != DROP;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= WAIT_IDLE;
      rx_dv_q <= 1'b0;
      ph_q    <= 1'b0;
      hi_q    <= '0;
      idx_q   <= '0;
      pre_q   <= '0;
      len_q   <= '0;
      pay_q   <= '0;
      crc_q   <= '0;
      mac_q   <= 1'b0;
      bc_q    <= 1'b0;
      od_q    <= '0;
      ov_q    <= 1'b0;
      sof_q   <= 1'b0;
      eof_q   <= 1'b0;
      done_q  <= 1'b0;
      ok_q    <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rx_dv_q <= rx_dv;
      ph_q    <= ph_d;
      hi_q    <= hi_d;
      idx_q   <= idx_d;
      pre_q   <= pre_d;
      len_q   <= len_d;
      pay_q   <= pay_d;
      crc_q   <= crc_d;
      mac_q   <= mac_d;
      bc_q    <= bc_d;
      od_q    <= od_d;
      ov_q    <= ov_d;
      sof_q   <= sof_d;
      eof_q   <= eof_d;
      done_q  <= done_d;
      ok_q    <= ok_d;
      drop_q  <= drop_d;
    end
  end

  assign od       = od_q;
  assign od_valid = ov_q;
  assign od_sof   = sof_q;
  assign od_eof   = eof_q;
  assign pkt_done = done_q;
  assign pkt_ok   = ok_q;
  assign drop     = drop_q;
endmodule

// File: doc/udp_packet_rx.md
Name: udp_packet_rx

Overview:
- Receive-side counterpart of the hardcoded UDP packet generator.
- Accepts an Ethernet byte or nibble stream qualified by rx_dv, strips the preamble and SFD, and filters the frame on destination MAC, IPv4, UDP protocol and destination port.
- Streams the UDP payload out with frame markers, checks the Ethernet FCS (CRC32), and reports a per-frame status pulse.
- Sits between the PHY-side input and user logic in loopback and bring-up designs.

Parameters:
- MODE, "BYTES": "BYTES" means id[7:0] carries one byte per cycle; "NIBBLES" means id[3:0] carries one nibble per cycle, high nibble first, id[7:4] ignored.
- MAC_ADDR, 48'hD8D38526C578: accepted destination MAC. Broadcast FF:FF:FF:FF:FF:FF is also accepted.
- UDP_PORT, 16'hC360: accepted UDP destination port.

Ports:
- clk  in  1  clock
- nrst  in  1  reset, asynchronous, active-low
- rx_dv  in  1  input data valid, high for the whole frame
- id  in  8  input data
- od  out  8  payload byte
- od_valid  out  1  od holds a valid payload byte
- od_sof  out  1  first payload byte, qualified by od_valid
- od_eof  out  1  last payload byte per UDP length, qualified by od_valid
- pkt_done  out  1  one-cycle end-of-frame pulse, only for frames that passed the header filter
- pkt_ok  out  1  status, valid only while pkt_done is high
- drop  out  1  one-cycle pulse when a frame is rejected by the filter

Behaviour:
- Reset: all outputs are 0. The FSM goes to WAIT_IDLE. Internal counters and the CRC register are cleared. Reset may be asserted at any time; an in-flight frame is discarded with no pkt_done.
- Byte assembly:
  - BYTES mode: every rx_dv=1 cycle delivers one byte.
  - NIBBLES mode: the nibble phase resets on each rx_dv rising edge. The first nibble is [7:4], the second is [3:0]; the byte is complete on the second nibble.
  - rx_dv falling with an odd nibble count is treated as truncation.
- FSM states:
  - WAIT_IDLE: wait for rx_dv=0, then go to IDLE. This prevents a mid-frame start after reset.
  - IDLE: the first byte must be 0x55, giving PREAMBLE. Any other byte gives DROP.
  - PREAMBLE: 0x55 stays in PREAMBLE; 0xD5 gives HEADER and resets frame index idx and the CRC register to 0xFFFFFFFF. Any other byte, or more than 7 bytes of 0x55, gives DROP.
  - HEADER: per-index checks on each complete byte. Any mismatch gives DROP.
    - idx 0-5: destination MAC equals MAC_ADDR, or all bytes equal 0xFF.
    - idx 12-13: 0x08 0x00.
    - idx 14: 0x45.
    - idx 23: 0x11.
    - idx 36-37: UDP_PORT.
    - idx 38-39: UDP length L. L<8 gives DROP.
    - idx 41: go to PAYLOAD if L>8, else FCS_WAIT.
  - PAYLOAD: emit bytes idx 42 through 41+(L-8). Then go to FCS_WAIT.
  - FCS_WAIT: consume remaining pad and FCS bytes, CRC only.
  - DROP: ignore input until rx_dv=0, then go to IDLE. drop pulses once, on entry.
- End of frame: rx_dv falling while in HEADER, PAYLOAD or FCS_WAIT pulses pkt_done one cycle later, then the FSM goes to IDLE. rx_dv falling in PREAMBLE goes to IDLE silently.
- pkt_ok = 1 only if all of the following hold:
  - the CRC register equals the residue 0xDEBB20E3;
  - all L-8 payload bytes were emitted;
  - the nibble count was even.
- CRC: reflected CRC32, polynomial 0x04C11DB7 (reflected 0xEDB88320). Updated on every complete byte after the SFD, including the FCS. One byte per update, combinational update function.
- Output latency: od and od_valid are registered, asserted one clk after the cycle the byte completes. od_sof coincides with payload byte 0. od_eof coincides with payload byte L-9.
- Output hold between bytes:
  - od_valid is low between bytes in NIBBLES mode.
  - od holds its last value when od_valid=0.
- idx is 11 bits and saturates at 2047; frames longer than that still end normally.

Test Plan:
- Nominal frame, MODE="BYTES": drive 7×0x55, 0xD5, then the generator's 60-byte frame (dst MAC D8D38526C578, IP 45 00 002E, proto 11, port C350→C360, L=0x001A), then FCS E3 8E DF 1F, rx_dv=1 throughout. Required response:
  - 18 od_valid bytes: 00 00 01 02 03 04 then 12×01;
  - od_sof on byte 0, od_eof on byte 17;
  - pkt_done with pkt_ok=1 one clk after rx_dv falls.
- Same frame in MODE="NIBBLES", high nibble first. Required response: identical payload, od_valid every second cycle, pkt_ok=1.
- Corrupted FCS: last FCS byte 0x1E. Required response: full payload streamed, pkt_done with pkt_ok=0.
- Filter rejects:
  - dst port 0xC361, or proto 0x06, or MAC byte 5 = 0x79: one drop pulse, no od_valid, no pkt_done.
  - Broadcast MAC: accepted, pkt_ok=1 only if the FCS in the stimulus is recomputed.
- Truncation: rx_dv falls after payload byte 9. Required response: 10 od_valid bytes, no od_eof, pkt_done with pkt_ok=0. The next nominal frame is then received with pkt_ok=1.
- Reset mid-payload: nrst low for 3 clk during payload byte 5. Required response:
  - all outputs 0 immediately;
  - with rx_dv still high after reset, no output for the rest of that frame;
  - the following frame is received with pkt_ok=1.
